// File: rtl/dr32e_multdiv.sv
// Iterative radix-2 multiply/divide unit for the dr32e execute stage (RV32M).
// One bit per cycle on operand magnitudes; sign correction applied in a single fix-up cycle.
module dr32e_multdiv #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ITER   = DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              ready_o,
  input  logic              kill_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] operand_a_i,
  input  logic [DATA_W-1:0] operand_b_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] result_o,
  output logic              div_by_zero_o
);

  localparam int unsigned CW = $clog2(ITER);

  if (DATA_W != 32 || ITER != DATA_W) begin : g_bad_width
    $error("dr32e_multdiv supports only DATA_W = ITER = 32");
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_W-1:0]     mag_q, mag_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic                  negrem_q, negrem_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic                  valid_q, valid_d;
  logic                  dbz_q, dbz_d;

  logic                  a_signed, b_signed, sa, sb;
  logic [DATA_W-1:0]     abs_a, abs_b;
  logic [DATA_W:0]       mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0]   prod_fix;
  logic [DATA_W-1:0]     quo_fix, rem_fix, fix_res;

  always_comb begin
    a_signed = !(op_i == 3'd3 || op_i == 3'd5 || op_i == 3'd7);
    b_signed = !(op_i == 3'd2 || op_i == 3'd3 || op_i == 3'd5 || op_i == 3'd7);
    sa       = a_signed & operand_a_i[DATA_W-1];
    sb       = b_signed & operand_b_i[DATA_W-1];
    abs_a    = sa ? -operand_a_i : operand_a_i;
    abs_b    = sb ? -operand_b_i : operand_b_i;
  end

  // Mul: multiplier sits in acc low half and shifts out as the product shifts in.
  // Div: dividend sits in acc low half and is replaced by quotient bits, MSB first.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    div_shift = {rem_q, acc_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, mag_q};
  end

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    rem_fix  = negrem_q ? -rem_q : rem_q;
    case (op_q)
      3'd0:          fix_res = prod_fix[DATA_W-1:0];
      3'd1, 3'd2,
      3'd3:          fix_res = prod_fix[2*DATA_W-1:DATA_W];
      3'd4, 3'd5:    fix_res = quo_fix;
      default:       fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    negrem_d = negrem_q;
    result_d = result_q;
    valid_d  = 1'b0;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (req_i && !kill_i) begin
          op_d     = op_i;
          cnt_d    = '0;
          rem_d    = '0;
          neg_d    = sa ^ sb;
          negrem_d = sa;
          if (op_i[2]) begin
            mag_d = abs_b;
            acc_d = {{DATA_W{1'b0}}, abs_a};
          end else begin
            mag_d = abs_a;
            acc_d = {{DATA_W{1'b0}}, abs_b};
          end
          if (op_i[2] && operand_b_i == '0) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            dbz_d    = 1'b1;
            result_d = op_i[1] ? operand_a_i : '1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[2]) begin
            rem_d = div_diff[DATA_W] ? div_shift[DATA_W-1:0] : div_diff[DATA_W-1:0];
            acc_d = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-2:0], ~div_diff[DATA_W]};
          end else begin
            acc_d = {mul_sum, acc_q[DATA_W-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_DONE;
          valid_d  = 1'b1;
          dbz_d    = 1'b0;
          result_d = fix_res;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      mag_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      negrem_q <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      negrem_q <= negrem_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      dbz_q    <= dbz_d;
    end
  end

  // A kill arriving during the DONE cycle must still squash the strobe.
  assign valid_o       = valid_q & ~kill_i;
  assign ready_o       = (state_q == S_IDLE);
  assign result_o      = result_q;
  assign div_by_zero_o = dbz_q & valid_q;

endmodule

// File: tb/tb_dr32e_multdiv.sv
// Scoreboard bench for dr32e_multdiv: driver pushes reference results, monitor checks every valid_o.
module tb_dr32e_multdiv;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic        ready_o, valid_o, div_by_zero_o;
  logic [31:0] result_o;

  dr32e_multdiv #(.DATA_W(32), .ITER(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .ready_o(ready_o),
    .kill_i(kill_i), .op_i(op_i), .operand_a_i(operand_a_i),
    .operand_b_i(operand_b_i), .valid_o(valid_o), .result_o(result_o),
    .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic from the RV32M definitions.
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic d);
    longint sa, sbv, ua, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    d   = 1'b0;
    p   = '0;
    case (op)
      3'd0: begin p = sa * sbv; r = p[31:0]; end
      3'd1: begin p = sa * sbv; r = p[63:32]; end
      3'd2: begin p = sa * ub;  r = p[63:32]; end
      3'd3: begin p = ua * ub;  r = p[63:32]; end
      3'd4: if (b == 0) begin r = 32'hFFFFFFFF; d = 1'b1; end
            else begin p = sa / sbv; r = p[31:0]; end
      3'd5: if (b == 0) begin r = 32'hFFFFFFFF; d = 1'b1; end
            else begin p = ua / ub; r = p[31:0]; end
      3'd6: if (b == 0) begin r = a; d = 1'b1; end
            else begin p = sa % sbv; r = p[31:0]; end
      default: if (b == 0) begin r = a; d = 1'b1; end
               else begin p = ua % ub; r = p[31:0]; end
    endcase
  endfunction

  always @(negedge clk_i) begin
    if (rst_ni && valid_o) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got valid with result %h, required no valid", result_o);
      end else begin
        mon_e = sb.pop_front();
        check("result", result_o, mon_e.res);
        check("div_by_zero", {31'b0, div_by_zero_o}, {31'b0, mon_e.dbz});
        check("valid_cycle", cyc, mon_e.cyc);
        check("ready_with_valid", {31'b0, ready_o}, 32'd0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk_i);
    while (!ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) check("ready_timeout", {31'b0, ready_o}, 32'd1);
  endtask

  // kill_iter < 0: normal op; otherwise kill at that CALC iteration (no result expected).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int kill_iter);
    logic [31:0] r;
    logic d;
    int lat, n;
    wait_ready();
    op_i = op; operand_a_i = a; operand_b_i = b; req_i = 1'b1;
    ref_model(op, a, b, r, d);
    lat = d ? 1 : 34;
    if (kill_iter < 0) sb.push_back('{r, d, cyc + lat});
    @(negedge clk_i);
    req_i = 1'b0;
    op_i = $urandom_range(7, 0); operand_a_i = $urandom(); operand_b_i = $urandom();
    if (kill_iter >= 0) begin
      repeat (kill_iter) @(negedge clk_i);
      kill_i = 1'b1;
      @(negedge clk_i);
      kill_i = 1'b0;
      check("ready_after_kill", {31'b0, ready_o}, 32'd1);
    end else begin
      n = 0;
      while (!ready_o && n < 100) begin
        @(negedge clk_i);
        n++;
      end
      check("ready_return_cycle", n, lat);
    end
  endtask

  logic [31:0] ra, rb;

  initial begin
    #12;
    check("reset_ready", {31'b0, ready_o}, 32'd1);
    check("reset_valid", {31'b0, valid_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    issue(3'd0, 32'hFFFFFFFD, 32'd7, -1);
    issue(3'd1, 32'hFFFFFFFD, 32'd7, -1);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, -1);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, -1);
    issue(3'd4, 32'hFFFFFFF9, 32'd2, -1);
    issue(3'd6, 32'hFFFFFFF9, 32'd2, -1);
    issue(3'd5, 32'd100, 32'd0, -1);
    issue(3'd7, 32'd100, 32'd0, -1);
    issue(3'd4, 32'h12345678, 32'd0, -1);
    issue(3'd5, 32'd1000, 32'd7, 10);
    issue(3'd7, 32'd1000, 32'd7, -1);

    // Asynchronous reset mid-CALC.
    wait_ready();
    op_i = 3'd3; operand_a_i = 32'hDEADBEEF; operand_b_i = 32'h12345; req_i = 1'b1;
    @(negedge clk_i);
    req_i = 1'b0;
    repeat (5) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("midreset_ready", {31'b0, ready_o}, 32'd1);
    check("midreset_valid", {31'b0, valid_o}, 32'd0);
    check("midreset_result", result_o, 32'd0);
    check("midreset_dbz", {31'b0, div_by_zero_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // req with kill in IDLE must not be accepted.
    @(negedge clk_i);
    op_i = 3'd5; operand_a_i = 32'd9; operand_b_i = 32'd0; req_i = 1'b1; kill_i = 1'b1;
    @(negedge clk_i);
    req_i = 1'b0; kill_i = 1'b0;
    check("req_kill_ready", {31'b0, ready_o}, 32'd1);
    repeat (3) @(negedge clk_i);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(7, 0))
        0: rb = 32'd0;
        1: rb = $urandom_range(9, 1);
        2: ra = 32'h80000000;
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      issue(3'($urandom_range(7, 0)), ra, rb, -1);
    end

    repeat (5) @(negedge clk_i);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
